// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths and stage-register types for the fpnorm normalizer
package fp_pkg;
   localparam int WIDTH    = 32;
   localparam int WEXP     = 8;
   localparam int WSIG     = 23;
   localparam int EXTRASIG = 24;
   localparam int SUMW     = WSIG + EXTRASIG + 3;
   localparam int LZW      = $clog2(SUMW);
   localparam int BIAS     = 127;
   localparam int EXPW     = WEXP + 2;
   localparam int EXP_MAX  = 2 * BIAS + 1;

   // Normalized word between S1 and S2; mant drops the carry bit, which is always 0 after S1
   typedef struct packed {
      logic                   sign;
      logic                   zero;
      logic signed [EXPW-1:0] exp;
      logic [SUMW-2:0]        mant;
   } s1_reg_t;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             ovf;
      logic             unf;
      logic             inexact;
   } s2_reg_t;
endpackage

// File: rtl/fplzc.sv
// rtl/fplzc.sv - combinational leading-zero counter over the hidden+fraction+guard field
module fplzc
   import fp_pkg::*;
(
   input  logic [SUMW-2:0] i_data,
   output logic [LZW-1:0]  o_count
);
   // Scan upward so the highest set bit is the last one to write the count
   always_comb begin
      o_count = LZW'(SUMW - 1);
      for (int i = 0; i < SUMW - 1; i++) begin
         if (i_data[i]) o_count = LZW'(SUMW - 2 - i);
      end
   end
endmodule

// File: rtl/fpnorm.sv
// rtl/fpnorm.sv - two-stage normalize / round-to-nearest-even / pack pipeline
// FPNORM_DENORM_EN keeps gradual-underflow subnormals; otherwise they flush to signed zero.
module fpnorm
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [WEXP-1:0]  in_exp,
   input  logic [SUMW-1:0]  in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_ovf,
   output logic             out_unf,
   output logic             out_inexact
);
   logic                   r_s1_valid;
   s1_reg_t                r_s1;
   logic                   r_out_valid;
   s2_reg_t                r_s2;

   logic                   w_s2_adv;
   logic                   w_in_ready;
   logic [LZW-1:0]         w_lz;
   logic [EXPW-1:0]        w_lz_ext;
   logic [EXPW-1:0]        w_shmax;
   logic [LZW-1:0]         w_shamt;
   logic signed [EXPW-1:0] w_exp_in;
   s1_reg_t                w_s1_next;

   logic                   w_hidden;
   logic                   w_g;
   logic                   w_s;
   logic                   w_inc;
   logic [WSIG+1:0]        w_rnd;
   logic signed [EXPW-1:0] w_exp_f;
   s2_reg_t                w_s2_next;

   assign w_s2_adv   = ~r_out_valid | out_ready;
   assign w_in_ready = ~r_s1_valid | w_s2_adv;

   fplzc u_lzc (
      .i_data  (in_sum[SUMW-2:0]),
      .o_count (w_lz)
   );

   // S1: left shift is capped so the exponent never drops below 1
   always_comb begin
      w_exp_in  = signed'({2'b00, in_exp});
      w_shmax   = (in_exp == '0) ? '0 : {2'b00, in_exp - WEXP'(1)};
      w_lz_ext  = {{(EXPW-LZW){1'b0}}, w_lz};
      w_shamt   = (w_lz_ext < w_shmax) ? w_lz : w_shmax[LZW-1:0];
      w_s1_next = '0;
      w_s1_next.sign = in_sign;
      w_s1_next.zero = (in_sum == '0);
      if (in_sum[SUMW-1]) begin
         w_s1_next.mant = {in_sum[SUMW-1:2], in_sum[1] | in_sum[0]};
         w_s1_next.exp  = w_exp_in + EXPW'(1);
      end else begin
         w_s1_next.mant = in_sum[SUMW-2:0] << w_shamt;
         w_s1_next.exp  = w_exp_in - signed'({{(EXPW-LZW){1'b0}}, w_shamt});
      end
   end

   // S2: round on {hidden, frac}; a carry out of that field bumps the exponent
   always_comb begin
      w_hidden = r_s1.mant[SUMW-2];
      w_g      = r_s1.mant[EXTRASIG];
      w_s      = |r_s1.mant[EXTRASIG-1:0];
      w_inc    = w_g & (w_s | r_s1.mant[EXTRASIG+1]);
      w_rnd    = {1'b0, r_s1.mant[SUMW-2:EXTRASIG+1]} + (WSIG+2)'(w_inc);
      w_exp_f  = '0;
      if (w_rnd[WSIG+1])   w_exp_f = r_s1.exp + EXPW'(1);
      else if (w_rnd[WSIG]) w_exp_f = w_hidden ? r_s1.exp : EXPW'(1);

      w_s2_next         = '0;
      w_s2_next.inexact = w_g | w_s;
      if (r_s1.zero) begin
         w_s2_next = '0;
      end else if (w_exp_f >= EXPW'(EXP_MAX)) begin
         w_s2_next.result  = {r_s1.sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
         w_s2_next.ovf     = 1'b1;
         w_s2_next.inexact = 1'b1;
`ifdef FPNORM_DENORM_EN
      end else begin
         w_s2_next.result = {r_s1.sign, w_exp_f[WEXP-1:0], w_rnd[WSIG-1:0]};
         w_s2_next.unf    = (w_exp_f == '0) & (|w_rnd[WSIG-1:0]);
      end
`else
      end else if (!w_hidden) begin
         w_s2_next.result  = {r_s1.sign, {(WIDTH-1){1'b0}}};
         w_s2_next.unf     = 1'b1;
         w_s2_next.inexact = 1'b1;
      end else begin
         w_s2_next.result = {r_s1.sign, w_exp_f[WEXP-1:0], w_rnd[WSIG-1:0]};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) r_s1 <= w_s1_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_s2        <= '0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) r_s2 <= w_s2_next;
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_result  = r_s2.result;
   assign out_ovf     = r_s2.ovf;
   assign out_unf     = r_s2.unf;
   assign out_inexact = r_s2.inexact;
endmodule

// File: tb/tb_fpnorm.sv
// tb/tb_fpnorm.sv - directed scoreboard bench for fpnorm (honours FPNORM_DENORM_EN)
module tb_fpnorm;
   import fp_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [WEXP-1:0]  in_exp;
   logic [SUMW-1:0]  in_sum;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_ovf;
   logic             out_unf;
   logic             out_inexact;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             ovf;
      logic             unf;
      logic             inx;
   } exp_t;

   exp_t        sb_q[$];
   string       tag_q[$];
   exp_t        cur_exp;
   string       cur_tag;
   logic        last_acc;
   logic [31:0] held;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   fpnorm dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_exp      (in_exp),
      .in_sum      (in_sum),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_ovf     (out_ovf),
      .out_unf     (out_unf),
      .out_inexact (out_inexact)
   );

   task automatic check_bit(input string tag, input logic obs, input logic req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, req);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   // One clock: sample at the falling edge, push on accept, pop/compare on output transfer
   task automatic step();
      exp_t  e;
      string t;
      @(negedge clk);
      last_acc = in_valid & in_ready;
      if (last_acc) begin
         sb_q.push_back(cur_exp);
         tag_q.push_back(cur_tag);
      end
      if (out_valid && out_ready) begin
         check_bit("sb_nonempty", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_word({t, "_result"}, out_result, e.res);
            check_word({t, "_flags"}, {29'd0, out_ovf, out_unf, out_inexact},
                       {29'd0, e.ovf, e.unf, e.inx});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag, input logic sg, input logic [WEXP-1:0] ex,
                       input logic [SUMW-1:0] sm, input logic [WIDTH-1:0] r,
                       input logic f_ovf, input logic f_unf, input logic f_inx);
      in_valid = 1'b1;
      in_sign  = sg;
      in_exp   = ex;
      in_sum   = sm;
      cur_exp  = '{r, f_ovf, f_unf, f_inx};
      cur_tag  = tag;
      last_acc = 1'b0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (last_acc) break;
      end
      check_bit({tag, "_accepted"}, last_acc, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 20; n++) begin
         if (sb_q.size() == 0) break;
         step();
      end
      check_word("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   localparam logic [SUMW-1:0] ONE = 1;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_sum    = '0;
      out_ready = 1'b1;
      cur_exp   = '0;
      cur_tag   = "";
      last_acc  = 1'b0;
      held      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_word("rst_result", out_result, 32'h0);
      check_word("rst_flags", {29'd0, out_ovf, out_unf, out_inexact}, 32'd0);

      send("one_plus_one", 1'b0, 8'd127, ONE << 49, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      check_bit("lat_edge1_not_valid", out_valid, 1'b0);
      step();
      check_bit("lat_edge2_valid", out_valid, 1'b1);

      send("cancel", 1'b0, 8'd127, ONE << 47, 32'h3F00_0000, 1'b0, 1'b0, 1'b0);
      send("zero", 1'b1, 8'd127, '0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      send("rne_tie_even", 1'b0, 8'd127, (ONE << 48) | (ONE << 24), 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
      send("rne_tie_odd", 1'b0, 8'd127, (ONE << 48) | (ONE << 25) | (ONE << 24),
           32'h3F80_0002, 1'b0, 1'b0, 1'b1);
      send("rne_carry", 1'b0, 8'd127, ((ONE << 25) - ONE) << 24, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
      send("overflow", 1'b0, 8'd254, ONE << 49, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
      send("neg_sticky", 1'b1, 8'd130, (ONE << 48) | (ONE << 24) | ONE, 32'hC100_0001, 1'b0, 1'b0, 1'b1);
      send("carry_lost_bit", 1'b0, 8'd127, (ONE << 49) | ONE, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
`ifdef FPNORM_DENORM_EN
      send("underflow", 1'b0, 8'd1, ONE << 45, 32'h0010_0000, 1'b0, 1'b1, 1'b0);
      send("capped_shift", 1'b0, 8'd3, ONE << 45, 32'h0040_0000, 1'b0, 1'b1, 1'b0);
      send("sub_to_min_norm", 1'b0, 8'd1, ((ONE << 24) - ONE) << 24, 32'h0080_0000, 1'b0, 1'b0, 1'b1);
`else
      send("underflow", 1'b0, 8'd1, ONE << 45, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
      send("capped_shift", 1'b1, 8'd3, ONE << 45, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      send("sub_to_min_norm", 1'b0, 8'd1, ((ONE << 24) - ONE) << 24, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
`endif
      drain();

      out_ready = 1'b0;
      send("bp0", 1'b0, 8'd127, ONE << 48, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
      send("bp1", 1'b0, 8'd128, ONE << 48, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_exp   = 8'd129;
      in_sum   = ONE << 48;
      check_bit("bp_in_ready_low", in_ready, 1'b0);
      check_bit("bp_out_valid", out_valid, 1'b1);
      held = out_result;
      check_word("bp_head_word", out_result, 32'h3F80_0000);
      step();
      check_bit("bp_no_accept", last_acc, 1'b0);
      check_word("bp_hold_result", out_result, held);
      check_bit("bp_hold_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      send("bp2", 1'b0, 8'd129, ONE << 48, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
      send("bp3", 1'b0, 8'd130, (ONE << 48) | (ONE << 25), 32'h4100_0001, 1'b0, 1'b0, 1'b0);
      drain();

      send("rst_word", 1'b0, 8'd127, ONE << 49, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb_q.delete();
      tag_q.delete();
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check_bit("midrst_in_ready", in_ready, 1'b1);
      check_word("midrst_result", out_result, 32'h0);
      step();
      step();
      check_bit("midrst_discarded", out_valid, 1'b0);

      send("post_rst", 1'b0, 8'd127, ONE << 47, 32'h3F00_0000, 1'b0, 1'b0, 1'b0);
      drain();
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
